wb_ibex_ctrl: RTL and testbench
===============================

WB_IBEX_CTRL -- requirements
Module: wb_ibex_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000, Wishbone base address of the register window.
REQ-002 SHALL have parameter MEM_AW, default 12, word-address width of the ibex program-memory port.
REQ-003 SHALL have parameter GNT_TIMEOUT, default 255, maximum wait cycles for mem_gnt_i.
REQ-004 Ports, one clock, reset asynchronous and active-high:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  async active-high reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data
- io_in  in  38  pad inputs
- io_out  out  38  pad outputs
- io_oeb  out  38  pad output-enable, active-low
- mem_req_o  out  1  program-memory write request
- mem_addr_o  out  MEM_AW  word address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables
- mem_gnt_i  in  1  request accepted
- ibex_rst_ni  out  1  core reset, active-low
- ibex_fetch_en_o  out  1  core fetch enable

Function
REQ-005 SHALL decode a hit when wbs_cyc_i & wbs_stb_i & wbs_adr_i[31:5]==BASE_ADR[31:5]; register = wbs_adr_i[4:2].
REQ-006 Registers: 0 CHECKPOINT rw[15:0]; 1 CTRL rw[1:0] (bit0 core_run, bit1 fetch_sw); 2 IO_SYNC ro[7:0]; 3 MEM_ADDR rw[MEM_AW-1:0]; 4 MEM_DATA wo; 5 STATUS ro (bit0 busy, bit1 timeout_err, W1C).
REQ-007 Register writes SHALL honour wbs_sel_i per byte; reads of wo/unmapped offsets (4, 6, 7) return 0.
REQ-008 Non-MEM_DATA accesses SHALL assert wbs_ack_o for exactly one cycle, the cycle after the hit is sampled; wbs_dat_o valid in that cycle, 0 otherwise.
REQ-009 No second ack SHALL be issued for a strobe already acked; a new hit is decoded only while FSM is IDLE and wbs_ack_o is low.
REQ-010 FSM states IDLE, MEMREQ, ACK; IDLE->MEMREQ on MEM_DATA write hit; MEMREQ->ACK on mem_gnt_i or wait counter reaching GNT_TIMEOUT; ACK->IDLE unconditionally.
REQ-011 In MEMREQ: mem_req_o=1, mem_addr_o=MEM_ADDR, mem_wdata_o/mem_be_o latched from wbs_dat_i/wbs_sel_i; stable until grant or timeout.
REQ-012 Grant in same cycle as first mem_req_o SHALL be accepted (minimum MEM_DATA latency: 3 cycles hit-to-ack).
REQ-013 On grant, MEM_ADDR SHALL increment by 1 modulo 2^MEM_AW (max wraps to 0); on timeout, MEM_ADDR unchanged, timeout_err set.
REQ-014 wbs_ack_o SHALL assert in ACK for both grant and timeout; STATUS.busy = (state != IDLE).
REQ-015 io_in[7:0] SHALL pass a 2-flop synchronizer into IO_SYNC.
REQ-016 io_out[31:16]=CHECKPOINT, io_oeb[31:16]=0; io_oeb of all other bits =1, io_out of other bits =0.
REQ-017 ibex_rst_ni = CTRL.core_run & ~busy; ibex_fetch_en_o = ibex_rst_ni & (CTRL.fetch_sw | IO_SYNC[5]).
REQ-018 A CTRL write while busy SHALL take effect normally; core stays in reset until FSM IDLE.

Reset
REQ-019 On wb_rst_i assertion, asynchronously: all registers, synchronizer, wait counter =0; FSM IDLE; wbs_ack_o=0, wbs_dat_o=0, mem_req_o=0, io_out=0, io_oeb[31:16]=0, others 1, ibex_rst_ni=0, ibex_fetch_en_o=0.
REQ-020 Reset mid-MEMREQ SHALL drop mem_req_o immediately and issue no ack; MEM_ADDR returns to 0.

Verification
REQ-021 Write CHECKPOINT=16'h0003 sel=4'b0011 -> ack next cycle, io_out[31:16]=16'h0003, io_oeb[31:16]=0.
REQ-022 MEM_ADDR=0x0FF, two MEM_DATA writes 32'h0000_0013/32'h0010_0073, gnt after 2 cycles -> mem writes at 0x0FF,0x100, MEM_ADDR reads 0x101.
REQ-023 MEM_ADDR=0xFFF, MEM_DATA write, gnt immediate -> ack 3 cycles after hit, MEM_ADDR=0x000.
REQ-024 MEM_DATA write with gnt tied low -> ack after 255 wait cycles, STATUS=2'b10, MEM_ADDR unchanged; write STATUS 2 -> reads 0.
REQ-025 CTRL=1, io_in[7:0]=8'b0010_0110 -> IO_SYNC=0x26 after 2 cycles, ibex_fetch_en_o=1; io_in[5]=0 -> fetch_en 0 after 2 cycles.
REQ-026 Assert wb_rst_i during MEMREQ -> mem_req_o=0 same cycle, no ack, all registers read 0 after release.

Source files
------------

// File: rtl/wb_ibex_ctrl.sv
// Wishbone register window that loads ibex program memory and gates ibex reset/fetch.
// Latency: register access acks 1 cycle after the hit; MEM_DATA write acks >= 3 cycles after the hit.
// Backpressure: MEM_DATA writes stall the bus in MEMREQ until mem_gnt_i or the grant timeout.
//
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; wbs_* Wishbone slave;
//        io_in/io_out/io_oeb pads; mem_* program-memory write port; ibex_rst_ni/ibex_fetch_en_o core control.
module wb_ibex_ctrl #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          MEM_AW      = 12,
    parameter int          GNT_TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [37:0]       io_in,
    output logic [37:0]       io_out,
    output logic [37:0]       io_oeb,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    output logic              ibex_rst_ni,
    output logic              ibex_fetch_en_o
);

    localparam int CW = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, MEMREQ, ACK} state_t;

    state_t            state;
    logic [15:0]       checkpoint;
    logic [1:0]        ctrl;
    logic [7:0]        io_meta;
    logic [7:0]        io_sync;
    logic [MEM_AW-1:0] mem_addr;
    logic              timeout_err;
    logic [CW-1:0]     wait_cnt;

    logic              busy;
    logic              hit;
    logic [2:0]        reg_sel;
    logic [31:0]       rdata;
    logic [31:0]       wr_val;
    logic              unused_ok;

    assign busy    = (state != IDLE);
    assign reg_sel = wbs_adr_i[4:2];
    // A hit is only taken in IDLE with ack low, so a strobe held through its
    // ack cycle is never decoded twice.
    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5])
               & (state == IDLE) & ~wbs_ack_o;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0: rdata[15:0]       = checkpoint;
            3'd1: rdata[1:0]        = ctrl;
            3'd2: rdata[7:0]        = io_sync;
            3'd3: rdata[MEM_AW-1:0] = mem_addr;
            3'd5: rdata[1:0]        = {timeout_err, busy};
            default: rdata = '0;
        endcase
    end

    // Byte-select merge of the write data over the current register value;
    // each rw register takes its low bits from this.
    always_comb begin
        wr_val = rdata;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                wr_val[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            checkpoint  <= '0;
            ctrl        <= '0;
            io_meta     <= '0;
            io_sync     <= '0;
            mem_addr    <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            mem_req_o   <= 1'b0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            io_meta   <= io_in[7:0];
            io_sync   <= io_meta;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (wbs_we_i && reg_sel == 3'd4) begin
                            state       <= MEMREQ;
                            mem_req_o   <= 1'b1;
                            mem_wdata_o <= wbs_dat_i;
                            mem_be_o    <= wbs_sel_i;
                            wait_cnt    <= '0;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= rdata;
                            if (wbs_we_i) begin
                                case (reg_sel)
                                    3'd0: checkpoint <= wr_val[15:0];
                                    3'd1: ctrl       <= wr_val[1:0];
                                    3'd3: mem_addr   <= wr_val[MEM_AW-1:0];
                                    3'd5: if (wbs_sel_i[0] && wbs_dat_i[1]) timeout_err <= 1'b0;
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                MEMREQ: begin
                    // Grant takes priority over a timeout in the same cycle.
                    if (mem_gnt_i) begin
                        state     <= ACK;
                        mem_req_o <= 1'b0;
                        mem_addr  <= mem_addr + 1'b1;
                    end else if (wait_cnt == CW'(GNT_TIMEOUT - 1)) begin
                        state       <= ACK;
                        mem_req_o   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr_o      = mem_addr;
    assign io_out          = {6'b0, checkpoint, 16'b0};
    assign io_oeb          = {6'h3F, 16'h0000, 16'hFFFF};
    // Core is held in reset while a program-memory write is in flight.
    assign ibex_rst_ni     = ctrl[0] & ~busy;
    assign ibex_fetch_en_o = ibex_rst_ni & (ctrl[1] | io_sync[5]);

    assign unused_ok = ^{wbs_adr_i[1:0], io_in[37:8]};

endmodule

// File: tb/tb_wb_ibex_ctrl.sv
module tb_wb_ibex_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TO   = 255;
    localparam logic [37:0] OEB  = 38'h3F_0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, wdat = 0;
    logic        ack;
    logic [31:0] rdat;
    logic [37:0] io_in = '0;
    logic [37:0] io_out, io_oeb;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        gnt = 1'b0;
    logic        core_rst_n, fetch_en;

    wb_ibex_ctrl #(.BASE_ADR(BASE), .MEM_AW(12), .GNT_TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_gnt_i(gnt),
        .ibex_rst_ni(core_rst_n), .ibex_fetch_en_o(fetch_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state of the register file, in spec terms.
    logic [15:0] m_ckpt;
    logic [1:0]  m_ctrl;
    logic [11:0] m_maddr;
    logic        m_terr;
    logic [7:0]  m_io;

    // Program memory responder: grants after gnt_delay waiting cycles, logs each accepted write.
    typedef struct packed {logic [11:0] a; logic [31:0] d; logic [3:0] b;} mw_t;
    mw_t mlog[$];
    int  gnt_delay = 0;
    int  wcnt = 0;

    always @(negedge clk) begin
        if (mem_req && !gnt) begin
            if (wcnt == gnt_delay) begin
                gnt = 1'b1;
                mlog.push_back('{a: mem_addr, d: mem_wdata, b: mem_be});
            end else begin
                wcnt++;
            end
        end else begin
            gnt  = 1'b0;
            wcnt = 0;
        end
    end

    function automatic logic [31:0] mread(input logic [2:0] off);
        case (off)
            3'd0: return {16'h0, m_ckpt};
            3'd1: return {30'h0, m_ctrl};
            3'd2: return {24'h0, m_io};
            3'd3: return {20'h0, m_maddr};
            3'd5: return {30'h0, m_terr, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                rd  = rdat;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        chk("ack_single", ack, 1'b0);
    endtask

    task automatic do_op(input logic w, input logic [2:0] off, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          lat, exp_lat;
        bit          memwr, granted;
        mw_t         e;
        memwr   = w && off == 3'd4;
        granted = memwr && gnt_delay < TO;
        exp_rd  = mread(off);
        exp_lat = !memwr ? 1 : (granted ? gnt_delay + 3 : TO + 2);
        mlog.delete();
        wb_xfer(w, BASE | {27'h0, off, 2'b00}, s, d, rd, lat);
        chk($sformatf("lat_off%0d", off), lat, exp_lat);
        if (!w) chk($sformatf("rd_off%0d", off), rd, exp_rd);
        if (memwr) begin
            chk("memwr_count", mlog.size(), granted ? 1 : 0);
            if (granted && mlog.size() > 0) begin
                e = mlog.pop_front();
                chk("memwr_entry", e, {m_maddr, d, s});
                m_maddr = m_maddr + 1;
            end
            if (!granted) m_terr = 1'b1;
        end else if (w) begin
            case (off)
                3'd0: begin
                    if (s[0]) m_ckpt[7:0]  = d[7:0];
                    if (s[1]) m_ckpt[15:8] = d[15:8];
                end
                3'd1: if (s[0]) m_ctrl = d[1:0];
                3'd3: begin
                    if (s[0]) m_maddr[7:0]  = d[7:0];
                    if (s[1]) m_maddr[11:8] = d[11:8];
                end
                3'd5: if (s[0] && d[1]) m_terr = 1'b0;
                default: ;
            endcase
        end
        chk("io_out", io_out, {6'h0, m_ckpt, 16'h0});
        chk("io_oeb", io_oeb, OEB);
        chk("core_rst_n", core_rst_n, m_ctrl[0]);
        chk("fetch_en", fetch_en, m_ctrl[0] & (m_ctrl[1] | m_io[5]));
    endtask

    task automatic set_io(input logic [7:0] v);
        @(negedge clk);
        io_in[7:0] = v;
        repeat (3) @(negedge clk);
        m_io = v;
    endtask

    initial begin
        m_ckpt = 0; m_ctrl = 0; m_maddr = 0; m_terr = 0; m_io = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 1'b0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_memreq", mem_req, 1'b0);
        chk("rst_io_out", io_out, 38'h0);
        chk("rst_io_oeb", io_oeb, OEB);
        chk("rst_core", core_rst_n, 1'b0);
        chk("rst_fetch", fetch_en, 1'b0);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) do_op(1'b0, 3'(r), 4'hF, 32'h0);

        // Checkpoint to pads with partial byte select
        do_op(1'b1, 3'd0, 4'b0011, 32'hDEAD_0003);
        chk("ckpt_pads", io_out[31:16], 16'h0003);

        // Two program words across 0x0FF -> 0x100
        gnt_delay = 2;
        do_op(1'b1, 3'd3, 4'hF, 32'h0000_00FF);
        do_op(1'b1, 3'd4, 4'hF, 32'h0000_0013);
        do_op(1'b1, 3'd4, 4'hF, 32'h0010_0073);
        do_op(1'b0, 3'd3, 4'hF, 32'h0);
        chk("maddr_0x101", m_maddr, 12'h101);

        // Top address wraps, immediate grant
        gnt_delay = 0;
        do_op(1'b1, 3'd3, 4'hF, 32'h0000_0FFF);
        do_op(1'b1, 3'd4, 4'h5, 32'hCAFE_F00D);
        do_op(1'b0, 3'd3, 4'hF, 32'h0);

        // Grant never arrives
        gnt_delay = 100000;
        do_op(1'b1, 3'd3, 4'hF, 32'h0000_0123);
        do_op(1'b1, 3'd4, 4'hF, 32'h1234_5678);
        do_op(1'b0, 3'd5, 4'hF, 32'h0);
        do_op(1'b0, 3'd3, 4'hF, 32'h0);
        do_op(1'b1, 3'd5, 4'h1, 32'h0000_0002);
        do_op(1'b0, 3'd5, 4'hF, 32'h0);

        // Fetch enable from synchronized pad bit 5
        do_op(1'b1, 3'd1, 4'h1, 32'h1);
        @(negedge clk);
        io_in[7:0] = 8'b0010_0110;
        @(negedge clk);
        chk("fetch_1flop", fetch_en, 1'b0);
        @(negedge clk);
        chk("fetch_2flop", fetch_en, 1'b1);
        m_io = 8'h26;
        do_op(1'b0, 3'd2, 4'hF, 32'h0);
        @(negedge clk);
        io_in[5] = 1'b0;
        @(negedge clk);
        chk("fetch_off_1flop", fetch_en, 1'b1);
        @(negedge clk);
        chk("fetch_off_2flop", fetch_en, 1'b0);
        m_io = 8'h06;

        // Address outside the window is ignored
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h20; sel = 4'hF; wdat = 32'hFFFF;
        begin
            int acks = 0;
            repeat (8) begin
                @(negedge clk);
                if (ack) acks++;
            end
            chk("miss_no_ack", acks, 0);
        end
        cyc = 0; stb = 0; we = 0;

        // Randomized mix against the model
        for (int n = 0; n < 150; n++) begin
            logic [2:0] off;
            if ($urandom_range(0, 9) == 0) set_io(8'($urandom));
            off       = 3'($urandom_range(0, 7));
            gnt_delay = ($urandom_range(0, 19) == 0) ? 300 : $urandom_range(0, 4);
            do_op(1'($urandom), off, 4'($urandom), $urandom);
        end

        // Reset in the middle of a pending memory write
        set_io(8'h00);
        gnt_delay = 100000;
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE | 32'h10; sel = 4'hF; wdat = 32'hAAAA_5555;
        @(negedge clk);
        chk("mid_memreq", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1 chk("rst_drops_req", mem_req, 1'b0);
        begin
            int acks = 0;
            repeat (4) begin
                @(negedge clk);
                if (ack) acks++;
            end
            cyc = 0; stb = 0; we = 0;
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (ack) acks++;
            end
            chk("rst_no_ack", acks, 0);
        end
        m_ckpt = 0; m_ctrl = 0; m_maddr = 0; m_terr = 0; m_io = 0;
        for (int r = 0; r < 8; r++) do_op(1'b0, 3'(r), 4'hF, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
